// File: rtl/spi_qch_ctrl.sv
// Q-Channel power-policy controller for the SPI master. It counts Wishbone idle
// cycles, requests quiescence from the wrapper, and brings the block back on activity or wake.
module spi_qch_ctrl #(
    parameter int IDLE_W = 8,
    parameter int TMO_W  = 10,
    parameter int DCNT_W = 8
) (
    input  logic              wb_clk_i,
    input  logic              wb_rst_ni,
    input  logic              idle_en_i,
    input  logic [IDLE_W-1:0] idle_thresh_i,
    input  logic              act_i,
    input  logic              wake_i,
    output logic              qreqn_o,
    input  logic              qacceptn_i,
    input  logic              qdeny_i,
    output logic              stopped_o,
    output logic [DCNT_W-1:0] deny_cnt_o,
    output logic [1:0]        err_o,
    input  logic              err_clr_i
);

    typedef enum logic [2:0] {
        ST_RUN     = 3'd0,
        ST_REQ     = 3'd1,
        ST_STOPPED = 3'd2,
        ST_EXIT    = 3'd3,
        ST_DENIED  = 3'd4
    } state_t;

    state_t              r_state;
    logic                r_qreqn;
    logic                r_stopped;
    logic [IDLE_W-1:0]   r_idle_cnt;
    logic [TMO_W-1:0]    r_tmo_cnt;
    logic [DCNT_W-1:0]   r_deny_cnt;
    logic [1:0]          r_err;

    state_t              w_state_nxt;
    logic                w_qreqn_nxt;
    logic                w_stopped_nxt;
    logic                w_busy;
    logic                w_idle_hit;
    logic                w_timed;
    logic                w_tmo_max;
    logic                w_tmo_set;
    logic                w_proto_err;
    logic                w_deny_inc;
    logic [IDLE_W-1:0]   w_idle_nxt;
    logic [TMO_W-1:0]    w_tmo_nxt;
    logic [DCNT_W-1:0]   w_deny_nxt;
    logic [1:0]          w_err_nxt;

    assign w_busy     = act_i | wake_i | ~idle_en_i;
    assign w_idle_hit = (r_idle_cnt == idle_thresh_i);
    assign w_timed    = (r_state == ST_REQ) || (r_state == ST_EXIT) || (r_state == ST_DENIED);
    assign w_tmo_max  = &r_tmo_cnt;

    // State register; outputs are registered from their next-state decode so they
    // change on the same edge that enters the state.
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
        if (!wb_rst_ni) begin
            r_state   <= ST_EXIT;
            r_qreqn   <= 1'b1;
            r_stopped <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_qreqn   <= w_qreqn_nxt;
            r_stopped <= w_stopped_nxt;
        end
    end

    // NOTE: every combinational output gets a default first, so no path can infer a latch.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_RUN:     if (!w_busy && w_idle_hit) w_state_nxt = ST_REQ;
            ST_REQ: begin
                if (!qacceptn_i)  w_state_nxt = ST_STOPPED;
                else if (qdeny_i) w_state_nxt = ST_DENIED;
            end
            ST_STOPPED: if (w_busy)      w_state_nxt = ST_EXIT;
            ST_EXIT:    if (qacceptn_i)  w_state_nxt = ST_RUN;
            ST_DENIED:  if (!qdeny_i)    w_state_nxt = ST_RUN;
            default:                     w_state_nxt = ST_EXIT;
        endcase
    end

    always_comb begin
        w_qreqn_nxt   = 1'b1;
        w_stopped_nxt = 1'b0;
        case (w_state_nxt)
            ST_REQ:     w_qreqn_nxt = 1'b0;
            ST_STOPPED: begin
                w_qreqn_nxt   = 1'b0;
                w_stopped_nxt = 1'b1;
            end
            default: ;
        endcase
    end

    // Counters and sticky error flags.
    always_comb begin
        w_idle_nxt = '0;
        if (r_state == ST_RUN && w_state_nxt == ST_RUN && !w_busy)
            w_idle_nxt = r_idle_cnt + 1'b1;

        w_tmo_nxt = r_tmo_cnt;
        if (w_state_nxt != r_state)
            w_tmo_nxt = '0;
        else if (w_timed && !w_tmo_max)
            w_tmo_nxt = r_tmo_cnt + 1'b1;

        // The first arrival at all-ones beats a clear; a saturated counter re-arms
        // the flag on every cycle that is not itself a clear cycle.
        w_tmo_set = w_timed && (w_state_nxt == r_state) && (&w_tmo_nxt)
                    && (!w_tmo_max || !err_clr_i);

        w_proto_err = 1'b0;
        if (r_state == ST_RUN)
            w_proto_err = ~qacceptn_i | qdeny_i;
        else if (r_state == ST_REQ)
            w_proto_err = ~qacceptn_i & qdeny_i;

        w_deny_inc = (r_state == ST_REQ) && qacceptn_i && qdeny_i && !(&r_deny_cnt);
        w_deny_nxt = w_deny_inc ? r_deny_cnt + 1'b1 : r_deny_cnt;

        w_err_nxt = (r_err & ~{2{err_clr_i}}) | {w_proto_err, w_tmo_set};
    end

    always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
        if (!wb_rst_ni) begin
            r_idle_cnt <= '0;
            r_tmo_cnt  <= '0;
            r_deny_cnt <= '0;
            r_err      <= '0;
        end else begin
            r_idle_cnt <= w_idle_nxt;
            r_tmo_cnt  <= w_tmo_nxt;
            r_deny_cnt <= w_deny_nxt;
            r_err      <= w_err_nxt;
        end
    end

    assign qreqn_o    = r_qreqn;
    assign stopped_o  = r_stopped;
    assign deny_cnt_o = r_deny_cnt;
    assign err_o      = r_err;

endmodule

// File: tb/tb_spi_qch_ctrl.sv
// Directed bench for spi_qch_ctrl: a per-cycle vector table for the main handshake
// flow, then hand-written sequences for saturation, timeout, threshold change and reset.
module tb_spi_qch_ctrl;

    logic       clk;
    logic       rst_n;
    logic       idle_en;
    logic [7:0] thresh;
    logic       act;
    logic       wake;
    logic       qreqn;
    logic       qacceptn;
    logic       qdeny;
    logic       stopped;
    logic [7:0] deny_cnt;
    logic [1:0] err;
    logic       err_clr;

    int n_tests = 0;
    int n_fail  = 0;

    spi_qch_ctrl #(.IDLE_W(8), .TMO_W(10), .DCNT_W(8)) dut (
        .wb_clk_i      (clk),
        .wb_rst_ni     (rst_n),
        .idle_en_i     (idle_en),
        .idle_thresh_i (thresh),
        .act_i         (act),
        .wake_i        (wake),
        .qreqn_o       (qreqn),
        .qacceptn_i    (qacceptn),
        .qdeny_i       (qdeny),
        .stopped_o     (stopped),
        .deny_cnt_o    (deny_cnt),
        .err_o         (err),
        .err_clr_i     (err_clr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic       en;
        logic [7:0] th;
        logic       act;
        logic       wake;
        logic       qa;
        logic       qd;
        logic       clr;
        logic       e_qreqn;
        logic       e_stopped;
        logic [7:0] e_deny;
        logic [1:0] e_err;
    } vec_t;

    vec_t vq[$];

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic add(input logic en, input logic [7:0] th, input logic a, input logic w,
                       input logic qa, input logic qd, input logic clr,
                       input logic eq, input logic es, input logic [7:0] ed, input logic [1:0] ee);
        vec_t v;
        v = '{en, th, a, w, qa, qd, clr, eq, es, ed, ee};
        vq.push_back(v);
    endtask

    task automatic add_n(input int n, input logic en, input logic [7:0] th, input logic a,
                         input logic w, input logic qa, input logic qd, input logic clr,
                         input logic eq, input logic es, input logic [7:0] ed, input logic [1:0] ee);
        for (int k = 0; k < n; k++) add(en, th, a, w, qa, qd, clr, eq, es, ed, ee);
    endtask

    task automatic deny_round();
        qdeny = 1'b1; tick();
        qdeny = 1'b0; tick();
        tick();
    endtask

    initial begin
        logic early;

        //     n  en th act wk qa qd clr | qreqn st deny err
        add_n(3, 1, 4, 0, 0, 0, 0, 0,   1, 0, 0, 0);   // EXIT while wrapper holds accept low
        add_n(1, 1, 4, 0, 0, 1, 0, 0,   1, 0, 0, 0);   // accept rises -> RUN
        add_n(4, 1, 4, 0, 0, 1, 0, 0,   1, 0, 0, 0);   // idle 1..4
        add_n(1, 1, 4, 0, 0, 1, 0, 0,   0, 0, 0, 0);   // 5th idle edge -> REQ
        add_n(1, 1, 4, 0, 0, 1, 0, 0,   0, 0, 0, 0);
        add_n(1, 1, 4, 0, 0, 0, 0, 0,   0, 1, 0, 0);   // accept -> STOPPED
        add_n(1, 1, 4, 0, 0, 0, 0, 0,   0, 1, 0, 0);
        add_n(1, 1, 4, 1, 0, 0, 0, 0,   1, 0, 0, 0);   // activity -> EXIT
        add_n(2, 1, 4, 0, 0, 0, 0, 0,   1, 0, 0, 0);
        add_n(1, 1, 4, 0, 0, 1, 0, 0,   1, 0, 0, 0);   // -> RUN
        add_n(3, 1, 4, 0, 0, 1, 0, 0,   1, 0, 0, 0);   // idle 1..3
        add_n(1, 1, 4, 1, 0, 1, 0, 0,   1, 0, 0, 0);   // activity clears count
        add_n(4, 1, 4, 0, 0, 1, 0, 0,   1, 0, 0, 0);
        add_n(1, 1, 4, 0, 0, 1, 0, 0,   0, 0, 0, 0);   // REQ after full interval
        add_n(1, 1, 4, 0, 0, 1, 1, 0,   1, 0, 1, 0);   // deny -> DENIED
        add_n(3, 1, 4, 0, 0, 1, 1, 0,   1, 0, 1, 0);
        add_n(1, 1, 4, 0, 0, 1, 0, 0,   1, 0, 1, 0);   // deny drops -> RUN
        add_n(4, 1, 4, 0, 0, 1, 0, 0,   1, 0, 1, 0);
        add_n(1, 1, 4, 0, 0, 1, 0, 0,   0, 0, 1, 0);   // retry only after thresh+1
        add_n(1, 1, 4, 0, 0, 0, 1, 0,   0, 1, 1, 2);   // accept+deny: accept wins, err[1]
        add_n(1, 1, 4, 0, 1, 0, 0, 0,   1, 0, 1, 2);   // wake -> EXIT
        add_n(1, 1, 4, 0, 0, 1, 0, 0,   1, 0, 1, 2);   // -> RUN
        add_n(1, 1, 4, 0, 0, 1, 0, 1,   1, 0, 1, 0);   // clear
        add_n(1, 1, 4, 0, 0, 1, 1, 0,   1, 0, 1, 2);   // deny in RUN: err[1], stay RUN
        add_n(1, 1, 4, 0, 0, 0, 0, 1,   1, 0, 1, 2);   // set beats clear
        add_n(1, 1, 4, 0, 0, 1, 0, 1,   1, 0, 1, 0);   // clear, idle count now 4
        add_n(1, 0, 4, 0, 0, 1, 0, 0,   1, 0, 1, 0);   // disabled: count cleared, no REQ
        add_n(1, 1, 0, 0, 0, 1, 0, 0,   0, 0, 1, 0);   // thresh 0: one idle cycle

        rst_n = 1'b0; idle_en = 1'b1; thresh = 8'd4; act = 1'b0; wake = 1'b0;
        qacceptn = 1'b0; qdeny = 1'b0; err_clr = 1'b0;
        repeat (3) tick();
        check("reset qreqn", {31'd0, qreqn}, 32'd1);
        check("reset stopped", {31'd0, stopped}, 32'd0);
        check("reset deny_cnt", {24'd0, deny_cnt}, 32'd0);
        check("reset err", {30'd0, err}, 32'd0);
        rst_n = 1'b1;

        for (int i = 0; i < vq.size(); i++) begin
            idle_en  = vq[i].en;
            thresh   = vq[i].th;
            act      = vq[i].act;
            wake     = vq[i].wake;
            qacceptn = vq[i].qa;
            qdeny    = vq[i].qd;
            err_clr  = vq[i].clr;
            tick();
            check($sformatf("vec%0d qreqn", i),   {31'd0, qreqn},    {31'd0, vq[i].e_qreqn});
            check($sformatf("vec%0d stopped", i), {31'd0, stopped},  {31'd0, vq[i].e_stopped});
            check($sformatf("vec%0d deny", i),    {24'd0, deny_cnt}, {24'd0, vq[i].e_deny});
            check($sformatf("vec%0d err", i),     {30'd0, err},      {30'd0, vq[i].e_err});
        end

        // Deny saturation: in REQ with thresh 0, each round is one denial.
        idle_en = 1'b1; thresh = 8'd0; act = 1'b0; wake = 1'b0;
        qacceptn = 1'b1; qdeny = 1'b0; err_clr = 1'b0;
        for (int i = 0; i < 254; i++) deny_round();
        check("deny reaches 255", {24'd0, deny_cnt}, 32'd255);
        check("deny back in REQ", {31'd0, qreqn}, 32'd0);
        for (int i = 0; i < 2; i++) deny_round();
        check("deny saturates", {24'd0, deny_cnt}, 32'd255);

        // Handshake timeout in REQ: entered REQ on the last edge.
        repeat (1022) tick();
        check("tmo not yet", {30'd0, err}, 32'd0);
        tick();
        check("tmo err set", {30'd0, err}, 32'd1);
        check("tmo qreqn held", {31'd0, qreqn}, 32'd0);
        err_clr = 1'b1; tick();
        check("tmo err cleared", {30'd0, err}, 32'd0);
        err_clr = 1'b0; tick();
        check("tmo err re-set", {30'd0, err}, 32'd1);
        check("tmo still REQ", {31'd0, qreqn}, 32'd0);
        qacceptn = 1'b0; tick();
        check("late accept stopped", {31'd0, stopped}, 32'd1);

        // Threshold lowered below a running count: count wraps, no early request.
        wake = 1'b1; tick();
        wake = 1'b0; qacceptn = 1'b1; thresh = 8'd4; tick();
        check("thresh run entered", {31'd0, qreqn}, 32'd1);
        repeat (3) tick();
        thresh = 8'd1;
        early = 1'b0;
        for (int k = 1; k < 255; k++) begin
            tick();
            if (qreqn !== 1'b1) early = 1'b1;
        end
        check("thresh no early req", {31'd0, early}, 32'd0);
        tick();
        check("thresh wrap req", {31'd0, qreqn}, 32'd0);

        // Asynchronous reset in the middle of a handshake.
        #3 rst_n = 1'b0;
        #1;
        check("midrst qreqn", {31'd0, qreqn}, 32'd1);
        check("midrst stopped", {31'd0, stopped}, 32'd0);
        check("midrst deny", {24'd0, deny_cnt}, 32'd0);
        check("midrst err", {30'd0, err}, 32'd0);
        tick();
        rst_n = 1'b1; thresh = 8'd0; qacceptn = 1'b1;
        tick();
        check("postrst run", {31'd0, qreqn}, 32'd1);
        tick();
        check("postrst req", {31'd0, qreqn}, 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
